// File: rtl/cpu_pkg.sv
// Shared CPU constants and types for the fetch stage.
package cpu_pkg;

  localparam int unsigned PC_W   = 32;
  localparam int unsigned INST_W = 32;

  localparam logic [PC_W-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

  // Fetch control state, used only when the alignment check is built in.
  typedef enum logic {
    FETCH_RUN  = 1'b0,
    FETCH_HALT = 1'b1
  } fetch_state_e;

  // Force a byte address onto a word boundary.
  function automatic logic [PC_W-1:0] word_align(input logic [PC_W-1:0] pc);
    return {pc[PC_W-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_skid_buf.sv
// One-entry skid buffer holding an instruction and its PC while decode stalls.
module fetch_skid_buf
  import cpu_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              capture,
  input  logic              drain,
  input  logic [INST_W-1:0] in_inst,
  input  logic [PC_W-1:0]   in_pc,
  output logic              valid,
  output logic [INST_W-1:0] inst,
  output logic [PC_W-1:0]   pc
);

  // Flush beats capture beats drain; payload only changes on capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= 1'b0;
      inst  <= '0;
      pc    <= '0;
    end else if (flush) begin
      valid <= 1'b0;
    end else if (capture) begin
      valid <= 1'b1;
      inst  <= in_inst;
      pc    <= in_pc;
    end else if (drain) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/inst_fetch.sv
// Instruction fetch stage: PC, synchronous imem issue, skid buffer, redirect.
// Optional macro INST_FETCH_ALIGN_CHECK_EN adds a RUN/HALT FSM that halts
// fetch on a misaligned redirect and raises the sticky fetch_misalign output.
module inst_fetch
  import cpu_pkg::*;
#(
  parameter int unsigned     ADDR_W   = 10,
  parameter logic [PC_W-1:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic [ADDR_W-1:0] imem_addr,
  output logic              imem_en,
  input  logic [INST_W-1:0] imem_douta,
  input  logic              redirect_valid,
  input  logic [PC_W-1:0]   redirect_pc,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [INST_W-1:0] out_inst,
  output logic [PC_W-1:0]   out_pc
`ifdef INST_FETCH_ALIGN_CHECK_EN
  ,
  output logic              fetch_misalign
`endif
);

  logic [PC_W-1:0]   pc_q;
  logic              req_q;
  logic [PC_W-1:0]   req_pc_q;
  logic              rst_done_q;
  logic              run;
  logic              issue;
  logic              capture;
  logic              drain;
  logic              buf_valid;
  logic [INST_W-1:0] buf_inst;
  logic [PC_W-1:0]   buf_pc;

`ifdef INST_FETCH_ALIGN_CHECK_EN
  fetch_state_e state_q;
  logic         misalign_q;

  // RUN/HALT control; HALT is left only through reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= FETCH_RUN;
      misalign_q <= 1'b0;
    end else begin
      case (state_q)
        FETCH_RUN: begin
          if (redirect_valid && (redirect_pc[1:0] != 2'b00)) begin
            state_q    <= FETCH_HALT;
            misalign_q <= 1'b1;
          end
        end
        FETCH_HALT: misalign_q <= 1'b1;
        default:    state_q    <= FETCH_RUN;
      endcase
    end
  end

  assign run            = (state_q == FETCH_RUN);
  assign fetch_misalign = misalign_q;
`else
  assign run = 1'b1;
`endif

  // Issue only when the read just returned can be consumed or nothing is pending.
  always_comb begin
    issue   = rst_done_q && run && !redirect_valid && !buf_valid
              && !(req_q && !out_ready);
    capture = run && !redirect_valid && req_q && !out_ready && !buf_valid;
    drain   = buf_valid && out_ready;
  end

  // PC and in-flight request tracking; redirect overrides any issue.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q       <= RESET_PC;
      req_q      <= 1'b0;
      req_pc_q   <= '0;
      rst_done_q <= 1'b0;
    end else begin
      rst_done_q <= 1'b1;
      if (redirect_valid) begin
        pc_q  <= word_align(redirect_pc);
        req_q <= 1'b0;
      end else if (issue) begin
        req_q    <= 1'b1;
        req_pc_q <= pc_q;
        pc_q     <= pc_q + 32'd4;
      end else begin
        req_q <= 1'b0;
      end
    end
  end

  fetch_skid_buf u_skid (
    .clk     (clk),
    .rst_n   (rst_n),
    .flush   (redirect_valid),
    .capture (capture),
    .drain   (drain),
    .in_inst (imem_douta),
    .in_pc   (req_pc_q),
    .valid   (buf_valid),
    .inst    (buf_inst),
    .pc      (buf_pc)
  );

  assign imem_addr = pc_q[ADDR_W+1:2];
  assign imem_en   = issue;

  // Output mux: buffered entry first, otherwise the fresh memory read.
  always_comb begin
    out_valid = run && !redirect_valid && (buf_valid || req_q);
    out_pc    = buf_valid ? buf_pc : req_pc_q;
    out_inst  = '0;
    if (out_valid) begin
      out_inst = buf_valid ? buf_inst : imem_douta;
    end
  end

endmodule

// File: tb/tb_inst_fetch.sv
// Self-checking bench for inst_fetch with a synchronous memory model and
// an in-order scoreboard of expected PCs.
module tb_inst_fetch;

  localparam int unsigned ADDR_W = 10;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [ADDR_W-1:0] imem_addr;
  logic              imem_en;
  logic [31:0]       imem_douta = 32'h0;
  logic              redirect_valid = 1'b0;
  logic [31:0]       redirect_pc = 32'h0;
  logic              out_valid;
  logic              out_ready = 1'b1;
  logic [31:0]       out_inst;
  logic [31:0]       out_pc;
`ifdef INST_FETCH_ALIGN_CHECK_EN
  logic              fetch_misalign;
`endif

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];
  logic [31:0] mon_pc;

  inst_fetch #(.ADDR_W(ADDR_W), .RESET_PC(32'h0000_0000)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_addr      (imem_addr),
    .imem_en        (imem_en),
    .imem_douta     (imem_douta),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_inst       (out_inst),
    .out_pc         (out_pc)
`ifdef INST_FETCH_ALIGN_CHECK_EN
    ,
    .fetch_misalign (fetch_misalign)
`endif
  );

  always #5 clk = ~clk;

  // Memory: word k holds 0x1000_0000 + k, one-cycle registered read.
  always @(posedge clk) begin
    if (imem_en) imem_douta <= 32'h1000_0000 + 32'(imem_addr);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] exp_inst(input logic [31:0] pc);
    logic [ADDR_W-1:0] a;
    a = pc[ADDR_W+1:2];
    return 32'h1000_0000 + 32'(a);
  endfunction

  task automatic push_stream(input logic [31:0] start);
    exp_q.delete();
    for (int i = 0; i < 64; i++) exp_q.push_back(start + 32'(i * 4));
  endtask

  // Move to 2 ns after the next falling edge; inputs change here.
  task automatic cyc();
    @(negedge clk);
    #2;
  endtask

  // Scoreboard: each accepted instruction must be the next expected PC.
  always @(negedge clk) begin
    #4;
    if (rst_n && out_valid && out_ready) begin
      check("sb_avail", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        mon_pc = exp_q.pop_front();
        check("sb_pc", out_pc, mon_pc);
        check("sb_inst", out_inst, exp_inst(mon_pc));
      end
    end
  end

  initial begin
    push_stream(32'h0);
    repeat (2) cyc();
    #1;
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_inst", out_inst, 32'd0);
    check("rst_pc", out_pc, 32'd0);
    check("rst_en", 32'(imem_en), 32'd0);
    check("rst_addr", 32'(imem_addr), 32'd0);

    cyc(); rst_n = 1'b1; #1;
    check("rel_en", 32'(imem_en), 32'd0);
    cyc(); #1;
    check("c1_en", 32'(imem_en), 32'd1);
    check("c1_addr", 32'(imem_addr), 32'd0);
    check("c1_valid", 32'(out_valid), 32'd0);
    cyc(); #1;
    check("c2_valid", 32'(out_valid), 32'd1);
    check("c2_inst", out_inst, 32'h1000_0000);
    check("c2_pc", out_pc, 32'd0);
    cyc(); #1;
    check("c3_pc", out_pc, 32'd4);

    // Stall three cycles while PC 8 is presented.
    cyc(); out_ready = 1'b0; #1;
    check("stall0_pc", out_pc, 32'd8);
    check("stall0_en", 32'(imem_en), 32'd0);
    repeat (2) begin
      cyc(); #1;
      check("stall_valid", 32'(out_valid), 32'd1);
      check("stall_pc", out_pc, 32'd8);
      check("stall_inst", out_inst, 32'h1000_0002);
      check("stall_en", 32'(imem_en), 32'd0);
    end
    cyc(); out_ready = 1'b1; #1;
    check("drain_pc", out_pc, 32'd8);
    check("drain_en", 32'(imem_en), 32'd0);
    cyc(); #1;
    check("bubble_valid", 32'(out_valid), 32'd0);
    check("bubble_en", 32'(imem_en), 32'd1);
    check("bubble_addr", 32'(imem_addr), 32'd3);
    cyc(); #1;
    check("resume_valid", 32'(out_valid), 32'd1);
    check("resume_pc", out_pc, 32'd12);
    repeat (2) cyc();

    // Redirect to 0x40 while streaming.
    cyc(); redirect_valid = 1'b1; redirect_pc = 32'h40; push_stream(32'h40); #1;
    check("redir_valid", 32'(out_valid), 32'd0);
    check("redir_en", 32'(imem_en), 32'd0);
    cyc(); redirect_valid = 1'b0; #1;
    check("redir1_valid", 32'(out_valid), 32'd0);
    check("redir1_en", 32'(imem_en), 32'd1);
    check("redir1_addr", 32'(imem_addr), 32'h10);
    cyc(); #1;
    check("tgt_valid", 32'(out_valid), 32'd1);
    check("tgt_pc", out_pc, 32'h40);
    check("tgt_inst", out_inst, 32'h1000_0010);
    repeat (3) cyc();

    // Address wrap at the top of the memory.
    cyc(); redirect_valid = 1'b1; redirect_pc = 32'hFFC; push_stream(32'hFFC); #1;
    cyc(); redirect_valid = 1'b0; #1;
    check("wrap_addr_top", 32'(imem_addr), 32'h3FF);
    cyc(); #1;
    check("wrap_pc", out_pc, 32'hFFC);
    check("wrap_inst", out_inst, 32'h1000_03FF);
    check("wrap_addr0", 32'(imem_addr), 32'd0);
    cyc(); #1;
    check("wrap2_pc", out_pc, 32'h1000);
    check("wrap2_inst", out_inst, 32'h1000_0000);

    // Async reset while the skid buffer holds an entry.
    cyc(); out_ready = 1'b0; #1;
    check("ms_pc", out_pc, 32'h1004);
    cyc(); #1;
    check("ms_buf_valid", 32'(out_valid), 32'd1);
    check("ms_buf_pc", out_pc, 32'h1004);
    rst_n = 1'b0; exp_q.delete(); push_stream(32'h0); #1;
    check("ar_valid", 32'(out_valid), 32'd0);
    check("ar_inst", out_inst, 32'd0);
    check("ar_pc", out_pc, 32'd0);
    check("ar_en", 32'(imem_en), 32'd0);
    check("ar_addr", 32'(imem_addr), 32'd0);
    cyc(); out_ready = 1'b1;
    cyc(); rst_n = 1'b1;
    cyc(); #1;
    check("rr_en", 32'(imem_en), 32'd1);
    check("rr_addr", 32'(imem_addr), 32'd0);
    cyc(); #1;
    check("rr_valid", 32'(out_valid), 32'd1);
    check("rr_pc", out_pc, 32'd0);
    check("rr_inst", out_inst, 32'h1000_0000);
    repeat (3) cyc();

`ifdef INST_FETCH_ALIGN_CHECK_EN
    // Misaligned redirect halts fetch until reset.
    cyc(); redirect_valid = 1'b1; redirect_pc = 32'h42; exp_q.delete(); #1;
    check("mis_flag0", 32'(fetch_misalign), 32'd0);
    cyc(); redirect_valid = 1'b0; #1;
    check("mis_flag", 32'(fetch_misalign), 32'd1);
    repeat (4) begin
      cyc(); #1;
      check("halt_valid", 32'(out_valid), 32'd0);
      check("halt_en", 32'(imem_en), 32'd0);
      check("halt_flag", 32'(fetch_misalign), 32'd1);
    end
`else
    // Low address bits of a redirect are ignored.
    cyc(); redirect_valid = 1'b1; redirect_pc = 32'h42; push_stream(32'h40); #1;
    cyc(); redirect_valid = 1'b0; #1;
    check("mis_addr", 32'(imem_addr), 32'h10);
    cyc(); #1;
    check("mis_pc", out_pc, 32'h40);
    check("mis_inst", out_inst, 32'h1000_0010);
`endif
    repeat (2) cyc();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
